// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding slot per functional unit, two broadcast
// ports per cycle, round-robin over occupied slots.
module cdb_arbiter #(
    parameter int NREQ = 3,
    parameter int TW   = 4,
    parameter int DW   = 32
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic                 ROBFlush,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*TW-1:0]   req_tag,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic [TW-1:0]        WT1,
    output logic [DW-1:0]        WD1,
    output logic                 WE1,
    output logic [TW-1:0]        WT2,
    output logic [DW-1:0]        WD2,
    output logic                 WE2,
    output logic                 busy
);

    localparam int RW = $clog2(NREQ);

    logic [NREQ-1:0] full_p0;
    logic [TW-1:0]   tag_p0  [NREQ];
    logic [DW-1:0]   data_p0 [NREQ];
    logic [RW-1:0]   rr;

    logic [NREQ-1:0] grant;
    logic [NREQ-1:0] xfer;
    logic            g1_vld, g2_vld;
    logic [RW-1:0]   g1_idx, g2_idx;
    logic [RW-1:0]   last_idx;
    logic [RW-1:0]   rr_nxt;
    int              idx;

    // Search occupied slots starting at rr; first hit drives port 1, second port 2.
    always_comb begin
        grant  = '0;
        g1_vld = 1'b0;
        g2_vld = 1'b0;
        g1_idx = '0;
        g2_idx = '0;
        idx    = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr) + k) % NREQ;
            if (full_p0[idx]) begin
                if (!g1_vld) begin
                    g1_vld      = 1'b1;
                    g1_idx      = RW'(idx);
                    grant[idx]  = 1'b1;
                end else if (!g2_vld) begin
                    g2_vld      = 1'b1;
                    g2_idx      = RW'(idx);
                    grant[idx]  = 1'b1;
                end
            end
        end
    end

    assign last_idx  = g2_vld ? g2_idx : g1_idx;
    assign rr_nxt    = (int'(last_idx) == NREQ - 1) ? '0 : last_idx + RW'(1);
    // A slot being drained this cycle can take a new result on the same edge.
    assign req_ready = (reset || ROBFlush) ? '0 : (~full_p0 | grant);
    assign xfer      = req_valid & req_ready;
    assign busy      = |full_p0;

    // Stage p0 -> broadcast registers
    always_ff @(posedge CLK) begin
        if (reset) begin
            full_p0 <= '0;
            rr      <= '0;
            WE1     <= 1'b0;
            WT1     <= '0;
            WD1     <= '0;
            WE2     <= 1'b0;
            WT2     <= '0;
            WD2     <= '0;
        end else if (ROBFlush) begin
            full_p0 <= '0;
            WE1     <= 1'b0;
            WT1     <= '0;
            WD1     <= '0;
            WE2     <= 1'b0;
            WT2     <= '0;
            WD2     <= '0;
        end else begin
            full_p0 <= (full_p0 & ~grant) | xfer;
            WE1     <= g1_vld;
            WT1     <= g1_vld ? tag_p0[g1_idx]  : '0;
            WD1     <= g1_vld ? data_p0[g1_idx] : '0;
            WE2     <= g2_vld;
            WT2     <= g2_vld ? tag_p0[g2_idx]  : '0;
            WD2     <= g2_vld ? data_p0[g2_idx] : '0;
            if (g1_vld) begin
                rr <= rr_nxt;
            end
        end
    end

    // Stage input -> p0 slot payload; xfer is already suppressed by reset/flush
    always_ff @(posedge CLK) begin
        for (int i = 0; i < NREQ; i++) begin
            if (xfer[i]) begin
                tag_p0[i]  <= req_tag[i*TW +: TW];
                data_p0[i] <= req_data[i*DW +: DW];
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized and directed bench for cdb_arbiter against a queue-based
// reference model of the slot/round-robin broadcast behaviour.
module tb_cdb_arbiter;

    localparam int NREQ = 3;
    localparam int TW   = 4;
    localparam int DW   = 32;

    logic                CLK = 1'b0;
    logic                reset;
    logic                ROBFlush;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*TW-1:0]  req_tag;
    logic [NREQ*DW-1:0]  req_data;
    logic [NREQ-1:0]     req_ready;
    logic [TW-1:0]       WT1, WT2;
    logic [DW-1:0]       WD1, WD2;
    logic                WE1, WE2;
    logic                busy;

    cdb_arbiter #(.NREQ(NREQ), .TW(TW), .DW(DW)) dut (
        .CLK(CLK), .reset(reset), .ROBFlush(ROBFlush),
        .req_valid(req_valid), .req_tag(req_tag), .req_data(req_data),
        .req_ready(req_ready),
        .WT1(WT1), .WD1(WD1), .WE1(WE1),
        .WT2(WT2), .WD2(WD2), .WE2(WE2),
        .busy(busy)
    );

    always #5 CLK = ~CLK;

    // Reference state
    bit          full_m [NREQ];
    logic [TW-1:0] tag_m  [NREQ];
    logic [DW-1:0] data_m [NREQ];
    int          rr_m;
    logic        exp_we1, exp_we2;
    logic [TW-1:0] exp_wt1, exp_wt2;
    logic [DW-1:0] exp_wd1, exp_wd2;

    int n_checks = 0;
    int n_errors = 0;

    // Watch for a specific tag being broadcast
    logic [TW-1:0] watch_tag;
    bit            watch_on = 0;
    bit            watch_seen = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_grants(output int g1, output int g2, output int n);
        int order[$];
        for (int k = 0; k < NREQ; k++)
            if (full_m[(rr_m + k) % NREQ]) order.push_back((rr_m + k) % NREQ);
        n  = (order.size() > 2) ? 2 : order.size();
        g1 = (n > 0) ? order[0] : -1;
        g2 = (n > 1) ? order[1] : -1;
    endfunction

    function automatic logic [NREQ-1:0] model_ready();
        int g1, g2, n;
        logic [NREQ-1:0] r;
        model_grants(g1, g2, n);
        r = '0;
        for (int i = 0; i < NREQ; i++)
            r[i] = !reset && !ROBFlush && (!full_m[i] || i == g1 || i == g2);
        return r;
    endfunction

    function automatic void model_edge();
        int g1, g2, n;
        logic [NREQ-1:0] rdy;
        model_grants(g1, g2, n);
        rdy = model_ready();
        if (reset || ROBFlush) begin
            for (int i = 0; i < NREQ; i++) full_m[i] = 0;
            if (reset) rr_m = 0;
            exp_we1 = 0; exp_wt1 = '0; exp_wd1 = '0;
            exp_we2 = 0; exp_wt2 = '0; exp_wd2 = '0;
            return;
        end
        exp_we1 = (n > 0);
        exp_wt1 = (n > 0) ? tag_m[g1]  : '0;
        exp_wd1 = (n > 0) ? data_m[g1] : '0;
        exp_we2 = (n > 1);
        exp_wt2 = (n > 1) ? tag_m[g2]  : '0;
        exp_wd2 = (n > 1) ? data_m[g2] : '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && rdy[i]) begin
                full_m[i] = 1;
                tag_m[i]  = req_tag[i*TW +: TW];
                data_m[i] = req_data[i*DW +: DW];
            end else if (i == g1 || i == g2) begin
                full_m[i] = 0;
            end
        end
        if (n > 0) rr_m = (((n == 2) ? g2 : g1) + 1) % NREQ;
    endfunction

    // One clock: check combinational outputs mid-cycle, advance model, check registered outputs
    task automatic step();
        bit bz;
        @(negedge CLK);
        check_eq("req_ready", 64'(req_ready), 64'(model_ready()));
        bz = 0;
        for (int i = 0; i < NREQ; i++) bz |= full_m[i];
        check_eq("busy", 64'(busy), 64'(bz));
        @(posedge CLK);
        model_edge();
        #1;
        check_eq("WE1", 64'(WE1), 64'(exp_we1));
        check_eq("WT1", 64'(WT1), 64'(exp_wt1));
        check_eq("WD1", 64'(WD1), 64'(exp_wd1));
        check_eq("WE2", 64'(WE2), 64'(exp_we2));
        check_eq("WT2", 64'(WT2), 64'(exp_wt2));
        check_eq("WD2", 64'(WD2), 64'(exp_wd2));
        if (watch_on && ((WE1 && WT1 == watch_tag) || (WE2 && WT2 == watch_tag)))
            watch_seen = 1;
    endtask

    task automatic set_req(input int i, input logic [TW-1:0] t, input logic [DW-1:0] d);
        req_tag[i*TW +: TW]  = t;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic do_reset();
        reset = 1; ROBFlush = 0; req_valid = '0;
        step();
        reset = 0;
    endtask

    task automatic single_req_019();
        req_valid = 3'b001;
        set_req(0, 4'h5, 32'hDEAD_BEEF);
        step();
        req_valid = '0;
        step();
        check_eq("r019_we1", 64'(WE1), 64'd1);
        check_eq("r019_wt1", 64'(WT1), 64'h5);
        check_eq("r019_wd1", 64'(WD1), 64'hDEAD_BEEF);
        check_eq("r019_we2", 64'(WE2), 64'd0);
        step();
        check_eq("r019_we1_off", 64'(WE1), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            full_m[i] = 0; tag_m[i] = '0; data_m[i] = '0;
        end
        rr_m = 0;
        exp_we1 = 0; exp_we2 = 0;
        exp_wt1 = '0; exp_wt2 = '0; exp_wd1 = '0; exp_wd2 = '0;
        req_tag = '0; req_data = '0; req_valid = '0;
        reset = 1; ROBFlush = 0;

        // Reset, then idle: all ready, not busy
        step();
        check_eq("rst_ready", 64'(req_ready), 64'd0);
        reset = 0;
        step();
        check_eq("idle_ready", 64'(req_ready), 64'h7);
        check_eq("idle_busy", 64'(busy), 64'd0);

        single_req_019();

        // Three-way contention from rr=0
        do_reset();
        req_valid = 3'b111;
        set_req(0, 4'h1, 32'h1111); set_req(1, 4'h2, 32'h2222); set_req(2, 4'h3, 32'h3333);
        step();
        req_valid = '0;
        step();
        check_eq("r020_c1_wt1", 64'(WT1), 64'h1);
        check_eq("r020_c1_wt2", 64'(WT2), 64'h2);
        check_eq("r020_c1_we2", 64'(WE2), 64'd1);
        step();
        check_eq("r020_c2_wt1", 64'(WT1), 64'h3);
        check_eq("r020_c2_we2", 64'(WE2), 64'd0);
        step();

        // Continuous stream on requester 0
        do_reset();
        req_valid = 3'b001;
        for (int c = 0; c < 8; c++) begin
            set_req(0, TW'(c + 2), DW'(32'hA000 + c));
            step();
            if (c > 0) check_eq("r021_tag", 64'(WT1), 64'(c + 1));
        end
        req_valid = '0;
        step(); step();

        // Flush with slots 0 and 2 full
        do_reset();
        req_valid = 3'b101;
        set_req(0, 4'h7, 32'h7777); set_req(2, 4'h8, 32'h8888);
        step();
        req_valid = '0; ROBFlush = 1;
        step();
        check_eq("r022_we1", 64'(WE1), 64'd0);
        check_eq("r022_busy", 64'(busy), 64'd0);
        ROBFlush = 0;
        step(); step();

        // Reset mid-operation with slots 0,1 full and a broadcast pending
        do_reset();
        req_valid = 3'b011;
        set_req(0, 4'hA, 32'hAAAA); set_req(1, 4'hB, 32'hBBBB);
        step();
        step();
        check_eq("r023_pre_we1", 64'(WE1), 64'd1);
        req_valid = '0; reset = 1;
        step();
        check_eq("r023_we1", 64'(WE1), 64'd0);
        check_eq("r023_busy", 64'(busy), 64'd0);
        reset = 0;
        single_req_019();

        // Starvation: 0 and 1 hammer, 2 valid once
        do_reset();
        set_req(0, 4'h1, 32'h100); set_req(1, 4'h2, 32'h200); set_req(2, 4'h9, 32'h900);
        req_valid = 3'b011;
        step(); step();
        req_valid = 3'b111;
        step();
        req_valid = 3'b011;
        watch_tag = 4'h9; watch_on = 1; watch_seen = 0;
        step(); step();
        check_eq("r024_seen", 64'(watch_seen), 64'd1);
        watch_on = 0;
        req_valid = '0;
        step(); step();

        // Random traffic with occasional flush and reset
        for (int c = 0; c < 400; c++) begin
            req_valid = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) set_req(i, TW'($urandom), $urandom);
            ROBFlush  = ($urandom_range(0, 15) == 0);
            reset     = ($urandom_range(0, 63) == 0);
            step();
        end
        reset = 0; ROBFlush = 0; req_valid = '0;
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
